// File: rtl/rv32_multicycle_cpu.sv
// Multi-cycle RV32I-subset bring-up core: instruction ROM, data RAM and one datapath.
// Each instruction walks FETCH/DECODE/EXEC[/MEM][/WB]. pc_write marks its final cycle.

module rv32_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] X [0:31];

    assign rd1 = X[rs1];
    assign rd2 = X[rs2];

    // X[0] is only ever cleared, so it reads as zero without a read-side mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) X[i] <= '0;
        end else if (we && rd != 5'd0) begin
            X[rd] <= wd;
        end
    end
endmodule

module rv32_datapath (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_out,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc_out,
    output logic        pc_write,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_we
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [2:0] {K_NOP, K_ALUR, K_ALUI, K_LUI, K_LW, K_SW, K_BR, K_JAL} kind_t;

    state_t      state;
    kind_t       kind;
    logic [31:0] ir, a, b, imm, alu_out, mdr;
    logic [31:0] imm_dec, op_b, alu_res, rd1, rd2, wd;
    logic        rf_we, take;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    // Anything outside the supported subset decodes as K_NOP: three cycles, PC+4, no writes.
    always_comb begin
        kind = K_NOP;
        case (opcode)
            7'b0110011: if ((funct7 == 7'h00 && funct3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7}) ||
                            (funct7 == 7'h20 && funct3 == 3'd0)) kind = K_ALUR;
            7'b0010011: if (funct3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7}) kind = K_ALUI;
            7'b0110111: kind = K_LUI;
            7'b0000011: if (funct3 == 3'd2) kind = K_LW;
            7'b0100011: if (funct3 == 3'd2) kind = K_SW;
            7'b1100011: if (funct3 == 3'd0 || funct3 == 3'd1) kind = K_BR;
            7'b1101111: kind = K_JAL;
            default:    kind = K_NOP;
        endcase
    end

    always_comb begin
        imm_dec = '0;
        case (opcode)
            7'b0010011, 7'b0000011: imm_dec = {{20{ir[31]}}, ir[31:20]};
            7'b0100011: imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011: imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            7'b1101111: imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            7'b0110111: imm_dec = {ir[31:12], 12'b0};
            default:    imm_dec = '0;
        endcase
    end

    always_comb begin
        op_b    = (kind == K_ALUR) ? b : imm;
        alu_res = a + op_b;
        if (kind == K_LUI) begin
            alu_res = imm;
        end else if (kind == K_ALUR || kind == K_ALUI) begin
            case (funct3)
                3'd0:    alu_res = (kind == K_ALUR && ir[30]) ? a - op_b : a + op_b;
                3'd2:    alu_res = {31'b0, $signed(a) < $signed(op_b)};
                3'd4:    alu_res = a ^ op_b;
                3'd6:    alu_res = a | op_b;
                3'd7:    alu_res = a & op_b;
                default: alu_res = a + op_b;
            endcase
        end
    end

    assign take = (state == EXEC) &&
                  (kind == K_JAL || (kind == K_BR && (funct3[0] ? (a != b) : (a == b))));

    // JAL writes its link in EXEC because it retires there; every other writer uses WB.
    assign rf_we = (state == WB) || (state == EXEC && kind == K_JAL);
    assign wd    = (state == EXEC) ? pc_out + 32'd4 : ((kind == K_LW) ? mdr : alu_out);

    assign dmem_addr  = alu_out;
    assign dmem_wdata = b;
    assign dmem_we    = (state == MEM) && (kind == K_SW);

    rv32_regfile u_regfile (
        .clk (clk),
        .rst_n (rst_n),
        .rs1 (ir[19:15]),
        .rs2 (ir[24:20]),
        .rd  (ir[11:7]),
        .we  (rf_we),
        .wd  (wd),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    // pc_write is registered one state ahead so it is high during the retiring cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc_write <= 1'b0;
            pc_out   <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            imm      <= '0;
            alu_out  <= '0;
            mdr      <= '0;
        end else begin
            if (pc_write) pc_out <= take ? pc_out + imm : pc_out + 32'd4;
            case (state)
                FETCH: begin
                    ir       <= imem_out;
                    state    <= DECODE;
                    pc_write <= 1'b0;
                end
                DECODE: begin
                    a        <= rd1;
                    b        <= rd2;
                    imm      <= imm_dec;
                    state    <= EXEC;
                    pc_write <= (kind == K_BR || kind == K_JAL || kind == K_NOP);
                end
                EXEC: begin
                    alu_out <= alu_res;
                    if (kind == K_BR || kind == K_JAL || kind == K_NOP) begin
                        state    <= FETCH;
                        pc_write <= 1'b0;
                    end else if (kind == K_LW || kind == K_SW) begin
                        state    <= MEM;
                        pc_write <= (kind == K_SW);
                    end else begin
                        state    <= WB;
                        pc_write <= 1'b1;
                    end
                end
                MEM: begin
                    mdr <= dmem_rdata;
                    if (kind == K_SW) begin
                        state    <= FETCH;
                        pc_write <= 1'b0;
                    end else begin
                        state    <= WB;
                        pc_write <= 1'b1;
                    end
                end
                default: begin
                    state    <= FETCH;
                    pc_write <= 1'b0;
                end
            endcase
        end
    end
endmodule

module rv32_multicycle_cpu #(
    parameter int    IMEM_WORDS = 256,
    parameter int    DMEM_WORDS = 256,
    parameter string IMEM_INIT  = "imem.hex"
) (
    input logic clk,
    input logic rst_n
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] rom  [0:IMEM_WORDS-1];
    logic [31:0] dmem [0:DMEM_WORDS-1];
    logic [31:0] pc, imem_word, dmem_addr, dmem_wdata, dmem_rdata;
    logic        pc_write, dmem_we;

    // Word addressing that drops high bits gives the modulo-depth wrap.
    assign imem_word  = rom[pc[IAW+1:2]];
    assign dmem_rdata = dmem[dmem_addr[DAW+1:2]];

    always_ff @(posedge clk) begin
        if (dmem_we) dmem[dmem_addr[DAW+1:2]] <= dmem_wdata;
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc[31:IAW+2], pc[1:0], dmem_addr[31:DAW+2], dmem_addr[1:0], pc_write};

    rv32_datapath u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_out   (imem_word),
        .dmem_rdata (dmem_rdata),
        .pc_out     (pc),
        .pc_write   (pc_write),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we)
    );
endmodule

// File: tb/tb_rv32_multicycle_cpu.sv
// Directed-program bench: each retirement (pc_write pulse) is matched against a queue
// of expected {pc, cycles-per-instruction}; register and memory state checked after each program.

module tb_rv32_multicycle_cpu;
    localparam int W = 36;
    localparam logic [6:0] OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_LUI = 7'b0110111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [W-1:0]  exp_q[$];
    logic [31:0]   prog[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;

    rv32_multicycle_cpu #(.IMEM_WORDS(256), .DMEM_WORDS(256), .IMEM_INIT("")) dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] e_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] e_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] e_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] e_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] xr(input int i);
        return dut.u_datapath.u_regfile.X[i];
    endfunction

    // Monitor: one expected entry consumed per pc_write pulse.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            cyc = 0;
        end else begin
            cyc++;
            if (dut.u_datapath.pc_write) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL retire: unexpected pc_write at pc %h", dut.u_datapath.pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({dut.u_datapath.pc_out, 4'(cyc)} !== e) begin
                        n_errors++;
                        $display("FAIL retire: got pc %h cycles %0d expected pc %h cycles %0d",
                                 dut.u_datapath.pc_out, cyc, e[35:4], e[3:0]);
                    end
                end
                cyc = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_ret(input logic [31:0] pc, input int c);
        exp_q.push_back({pc, 4'(c)});
    endtask

    task automatic push_seq(input logic [31:0] start, input int n, input int c);
        for (int i = 0; i < n; i++) push_ret(start + 32'(4 * i), c);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) dut.rom[i] = 32'h0;
        foreach (prog[i]) dut.rom[i] = prog[i];
        prog.delete();
    endtask

    task automatic reset_hold();
        logic [31:0] any_x;
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        any_x = '0;
        for (int i = 0; i < 32; i++) any_x = any_x | xr(i);
        chk("rst_pc", dut.u_datapath.pc_out, 32'h0);
        chk("rst_pc_write", {31'b0, dut.u_datapath.pc_write}, 32'h0);
        chk("rst_regs_or", any_x, 32'h0);
        chk("rst_ir", dut.u_datapath.ir, 32'h0);
    endtask

    task automatic release_rst();
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL drain: %0d retirements still pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Test 1/2: reset, then a simple ALU sequence.
        reset_hold();
        prog.push_back(e_i(5, 0, 3'd0, 1, OP_I));
        prog.push_back(e_i(3, 0, 3'd0, 2, OP_I));
        prog.push_back(e_r(7'h00, 2, 1, 3'd0, 3));
        prog.push_back(e_r(7'h20, 2, 1, 3'd0, 4));
        prog.push_back(e_j(0, 0));
        load_prog();
        push_seq(32'h0, 4, 4);
        push_seq(32'h10, 1, 3);
        push_seq(32'h10, 1, 3);
        release_rst();
        repeat (16) @(posedge clk);
        #1 chk("t2_pc_after_16", dut.u_datapath.pc_out, 32'h10);
        drain(100);
        chk("t2_x1", xr(1), 32'd5);
        chk("t2_x2", xr(2), 32'd3);
        chk("t2_x3", xr(3), 32'd8);
        chk("t2_x4", xr(4), 32'd2);

        // Test 3: signed compares, x0 write, logic ops, LUI, wrap-around.
        reset_hold();
        prog.push_back(e_i(5, 0, 3'd0, 1, OP_I));
        prog.push_back(e_i(-1, 0, 3'd0, 5, OP_I));
        prog.push_back(e_r(7'h00, 1, 5, 3'd2, 6));
        prog.push_back(e_r(7'h00, 5, 1, 3'd2, 8));
        prog.push_back(e_i(7, 0, 3'd0, 0, OP_I));
        prog.push_back(e_i(0, 5, 3'd2, 9, OP_I));
        prog.push_back(e_i(32'hF0, 5, 3'd4, 10, OP_I));
        prog.push_back(e_i(32'h30, 1, 3'd6, 11, OP_I));
        prog.push_back(e_i(-16, 5, 3'd7, 12, OP_I));
        prog.push_back({20'h12345, 5'd13, OP_LUI});
        prog.push_back(e_r(7'h00, 10, 12, 3'd7, 14));
        prog.push_back(e_r(7'h00, 13, 1, 3'd6, 15));
        prog.push_back(e_r(7'h00, 12, 10, 3'd4, 16));
        prog.push_back(e_r(7'h00, 1, 5, 3'd0, 17));
        prog.push_back(e_j(0, 0));
        load_prog();
        push_seq(32'h0, 14, 4);
        push_seq(32'h38, 1, 3);
        push_seq(32'h38, 1, 3);
        release_rst();
        drain(200);
        chk("t3_x5", xr(5), 32'hFFFF_FFFF);
        chk("t3_x6_slt", xr(6), 32'd1);
        chk("t3_x8_slt", xr(8), 32'd0);
        chk("t3_x0", xr(0), 32'd0);
        chk("t3_x9_slti", xr(9), 32'd1);
        chk("t3_x10_xori", xr(10), 32'hFFFF_FF0F);
        chk("t3_x11_ori", xr(11), 32'h0000_0035);
        chk("t3_x12_andi", xr(12), 32'hFFFF_FFF0);
        chk("t3_x13_lui", xr(13), 32'h1234_5000);
        chk("t3_x14_and", xr(14), 32'hFFFF_FF00);
        chk("t3_x15_or", xr(15), 32'h1234_5005);
        chk("t3_x16_xor", xr(16), 32'h0000_00FF);
        chk("t3_x17_wrap", xr(17), 32'h0000_0004);

        // Test 4: store then loads, including a negative offset.
        reset_hold();
        prog.push_back(e_i(8, 0, 3'd0, 3, OP_I));
        prog.push_back(e_s(4, 3, 0));
        prog.push_back(e_i(4, 0, 3'd2, 5, OP_LD));
        prog.push_back(e_i(12, 0, 3'd0, 6, OP_I));
        prog.push_back(e_i(-8, 6, 3'd2, 7, OP_LD));
        prog.push_back(e_j(0, 0));
        load_prog();
        push_ret(32'h0, 4);
        push_ret(32'h4, 4);
        push_ret(32'h8, 5);
        push_ret(32'hC, 4);
        push_ret(32'h10, 5);
        push_seq(32'h14, 1, 3);
        push_seq(32'h14, 1, 3);
        release_rst();
        drain(100);
        chk("t4_x5_lw", xr(5), 32'd8);
        chk("t4_x7_lw_neg", xr(7), 32'd8);
        chk("t4_dmem1", dut.dmem[1], 32'd8);

        // Test 5: branches, JAL link, unsupported opcode, halt loop.
        reset_hold();
        prog.push_back(e_i(5, 0, 3'd0, 1, OP_I));
        prog.push_back(e_b(8, 1, 1, 3'd0));
        prog.push_back(e_i(1, 0, 3'd0, 2, OP_I));
        prog.push_back(e_b(8, 1, 1, 3'd1));
        prog.push_back(e_i(2, 0, 3'd0, 3, OP_I));
        prog.push_back(e_j(8, 7));
        prog.push_back(e_i(3, 0, 3'd0, 4, OP_I));
        prog.push_back(e_b(8, 0, 1, 3'd1));
        prog.push_back(e_i(4, 0, 3'd0, 4, OP_I));
        prog.push_back(32'hFFFF_FFFF);
        prog.push_back(e_j(0, 0));
        load_prog();
        push_ret(32'h00, 4);
        push_ret(32'h04, 3);
        push_ret(32'h0C, 3);
        push_ret(32'h10, 4);
        push_ret(32'h14, 3);
        push_ret(32'h1C, 3);
        push_ret(32'h24, 3);
        push_seq(32'h28, 1, 3);
        push_seq(32'h28, 1, 3);
        push_seq(32'h28, 1, 3);
        release_rst();
        drain(100);
        chk("t5_x2_skipped", xr(2), 32'd0);
        chk("t5_x3_fallthru", xr(3), 32'd2);
        chk("t5_x4_skipped", xr(4), 32'd0);
        chk("t5_x7_link", xr(7), 32'h18);

        // Test 6: reset asserted during the MEM cycle of a store.
        reset_hold();
        dut.dmem[2] = 32'hA5A5_A5A5;
        prog.push_back(e_i(32'h55, 0, 3'd0, 3, OP_I));
        prog.push_back(e_s(8, 3, 0));
        prog.push_back(e_j(0, 0));
        load_prog();
        push_ret(32'h0, 4);
        push_ret(32'h4, 4);
        release_rst();
        drain(50);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_dmem_kept", dut.dmem[2], 32'hA5A5_A5A5);
        chk("t6_x3_cleared", xr(3), 32'h0);
        release_rst();
        #1 chk("t6_pc_restart", dut.u_datapath.pc_out, 32'h0);
        push_ret(32'h0, 4);
        push_ret(32'h4, 4);
        push_seq(32'h8, 1, 3);
        push_seq(32'h8, 1, 3);
        drain(100);
        chk("t6_dmem_rerun", dut.dmem[2], 32'h55);

        @(posedge clk); #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
